// File: rtl/i4001_mem_io_if.sv
`default_nettype none
// ============================================================================
// Module      : i4001_mem_io_if
// Description : Request/response bus between the CPU bus sequencer and the
//               i4001_mem_io memory/I-O block.
// Revision    : 1.0 - initial release
// ============================================================================
interface i4001_mem_io_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic              EN;
  logic              WE;
  logic              PORT;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              busy;

  // Sequencer side: issues requests, consumes read data and busy.
  modport master (
    output EN, WE, PORT, address, in,
    input  out, out_valid, busy
  );

  // Memory side: receives requests, returns read data and busy.
  modport slave (
    input  EN, WE, PORT, address, in,
    output out, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/i4001_mem_io.sv
`default_nettype none
// ============================================================================
// Module      : i4001_mem_io
// Description : Single-port synchronous memory with a 1- or 2-cycle read
//               pipeline, self-clearing after reset, plus a 4001-style I/O
//               port whose bits are individually fixed as input or output.
// Revision    : 1.0 - initial release
// ============================================================================
module i4001_mem_io #(
  parameter int              DATA_W  = 16,
  parameter int              ADDR_W  = 7,
  parameter int              RD_LAT  = 1,
  parameter int              IO_W    = 4,
  parameter logic [IO_W-1:0] IO_MASK = 4'b0011
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  i4001_mem_io_if.slave        bus,
  input  wire logic [IO_W-1:0] io_in,
  output logic      [IO_W-1:0] io_out,
  output logic      [IO_W-1:0] io_oe
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [IO_W-1:0]     sync1_q, sync1_d;
  logic [IO_W-1:0]     sync2_q, sync2_d;
  logic [IO_W-1:0]     io_out_q, io_out_d;
  logic                s0_valid_q, s0_valid_d;
  logic [DATA_W-1:0]   s0_data_q, s0_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_q, out_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic                rd_req;
  logic [IO_W-1:0]     port_bits;
  logic [DATA_W-1:0]   rd_word;

  // Sequencer: clear sweep after reset, then request decode and write steering.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    io_out_d  = io_out_q;
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.in;
    accept    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        // Counter parks on the top address instead of wrapping.
        if (clr_cnt_q == CNT_MAX) begin
          state_d = ST_READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        // No request is taken on a reset edge.
        accept = bus.EN & ~RST;
        if (accept && bus.WE) begin
          if (bus.PORT) begin
            io_out_d = bus.in[IO_W-1:0] & IO_MASK;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    rd_req = accept & ~bus.WE;
  end

  // Read source select: array word or the merged port view, captured at accept.
  always_comb begin
    sync1_d   = io_in;
    sync2_d   = sync1_q;
    port_bits = (io_out_q & IO_MASK) | (sync2_q & ~IO_MASK);
    rd_word   = '0;
    if (bus.PORT) begin
      rd_word[IO_W-1:0] = port_bits;
    end else begin
      rd_word = mem_q[bus.address];
    end
    s0_valid_d = rd_req;
    s0_data_d  = rd_req ? rd_word : s0_data_q;
  end

  // Optional extra stage; the final output register holds between reads.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_comb begin
        out_valid_d = s0_valid_q;
        out_d       = s0_valid_q ? s0_data_q : out_q;
      end
    end else begin : g_lat2
      logic              s1_valid_q, s1_valid_d;
      logic [DATA_W-1:0] s1_data_q, s1_data_d;

      // Middle stage next-state and output-register feed.
      always_comb begin
        s1_valid_d  = s0_valid_q;
        s1_data_d   = s0_valid_q ? s0_data_q : s1_data_q;
        out_valid_d = s1_valid_q;
        out_d       = s1_valid_q ? s1_data_q : out_q;
      end

      // Middle stage register; reset flushes any in-flight read.
      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
        end
      end
    end
  endgenerate

  // Control, synchroniser, port latch and read pipeline registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      io_out_q    <= '0;
      s0_valid_q  <= 1'b0;
      s0_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      io_out_q    <= io_out_d;
      s0_valid_q  <= s0_valid_d;
      s0_data_q   <= s0_data_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // Storage array: single write port, no reset so it maps onto inferred RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign io_out        = io_out_q;
  assign io_oe         = IO_MASK;

endmodule
`default_nettype wire

// File: doc/i4001_mem_io.md
# i4001_mem_io

Parametrised successor to the 4001 memory block: a single-port synchronous memory with a configurable read pipeline and a built-in 4001-style I/O port. After reset it zero-fills its whole array before accepting requests. It sits between the CPU bus sequencer and the board I/O pins. Storage is inferred, with no vendor core.

## Interface
- DATA_W, 16, memory word width (≥ IO_W)
- ADDR_W, 7, address width; depth = 2^ADDR_W words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- IO_W, 4, I/O port width
- IO_MASK, 4'b0011, per-bit direction: 1 = output bit, 0 = input bit

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  request valid
- WE  in  1  1 = write, 0 = read; sampled only with EN
- PORT  in  1  1 = request targets the I/O port, 0 = memory
- address  in  ADDR_W  memory word address; ignored when PORT=1
- in  in  DATA_W  write data
- out  out  DATA_W  read data, registered
- out_valid  out  1  one-cycle pulse when out carries new read data
- busy  out  1  1 = requests ignored (clear in progress)
- io_in  in  IO_W  pin inputs, asynchronous to CLK
- io_out  out  IO_W  output latch, registered
- io_oe  out  IO_W  constant = IO_MASK

## Operation
- FSM states: CLEAR, READY.
- RST=1 at any edge:
  - enter CLEAR with clear counter = 0.
  - out=0, out_valid=0, io_out=0, busy=1.
  - read pipeline flushed.
  - The 2-flop io_in synchroniser resets to 0.
- CLEAR:
  - each cycle writes 0 to mem[counter], then counter+1.
  - After writing address 2^ADDR_W−1, go to READY the next cycle.
  - busy=1 for exactly 2^ADDR_W cycles after reset deasserts.
  - EN ignored; nothing queued.
- READY: busy=0. One request may be accepted every cycle. A request is accepted when EN=1 and busy=0.
  - Memory write (PORT=0, WE=1): mem[address] ← in. No out_valid. out holds.
  - Memory read (PORT=0, WE=0): mem[address] appears on out RD_LAT cycles later with out_valid=1.
  - Port write (PORT=1, WE=1): io_out ← in[IO_W−1:0] & IO_MASK. Input bits stay 0.
  - Port read (PORT=1, WE=0): the returned word is zero-extended to DATA_W. Each bit i is io_out[i] if IO_MASK[i]=1, otherwise the synchronised io_in[i]. It is sampled in the accept cycle and returned with the same RD_LAT and out_valid as a memory read.
- Back-to-back reads are fully pipelined. Throughput is 1 per cycle and results come out in order.
- Read and write to the same address in consecutive cycles: the read sees the new data.
- Write then read of the same address in the next cycle returns the written value.
- out holds its last value when out_valid=0.
- Address wrap-around: none; every address is in range. The clear counter stops after the top address and does not wrap.

## Timing
- Read accepted at edge N → out/out_valid updated at edge N+RD_LAT. out_valid is high for one cycle per read.
- RD_LAT=2 adds an output register stage. Internal array read is always at edge N.
- Write takes effect at the accept edge. A read accepted at edge N+1 returns the new value.
- io_out changes at the accept edge of a port write.
- io_in reaches the read path 2 cycles after a pin change (synchroniser). Then +RD_LAT to out.
- RST asserted mid-read: the pending out_valid is suppressed. No stale pulse appears after reset.
- RST asserted mid-clear: the clear restarts from address 0.
- EN held high during CLEAR: no access occurs and no out_valid is produced. The first accepted request is in the cycle busy falls.

## Test plan
- Reset, DATA_W=16, ADDR_W=7:
  - busy=1 for exactly 128 cycles, then 0.
  - Read every address → each returns 16'h0000 with out_valid after RD_LAT.
- Write 16'hA5C3 to addr 7 and 16'h1234 to addr 127, then read 7, 127, 7 back-to-back:
  - out = A5C3, 1234, A5C3 on three consecutive cycles.
  - Run with RD_LAT=1 and RD_LAT=2.
- Mid-clear reset:
  - After 50 clear cycles, first write 16'hFFFF to addr 100 via a prior run, then pulse RST mid-clear.
  - busy lasts the full 128 cycles from the second reset.
  - addr 100 reads 0.
- Port with IO_MASK=4'b0011:
  - Port write in=16'h000F → io_out=4'b0011.
  - Drive io_in=4'b1000, wait 2 cycles, port read → out=16'h000B.
- Read accepted, RST asserted the next cycle → no out_valid for 4 cycles; out=0.
- Write addr 3 = 16'h0055 at edge N, read addr 3 at edge N+1 → out=16'h0055 at N+1+RD_LAT.
